// File: rtl/rpsc_pkg.sv
// Shared types and constants for the RPSC permit sequencer.
package rpsc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } rpsc_state_e;

  localparam int         N_ILK_MAX = 32;
  localparam logic [4:0] FF_UV     = 5'd31;

  // 1 + index of the lowest set bit; 0 when nothing is set.
  function automatic logic [4:0] ff_code(input logic [N_ILK_MAX-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = N_ILK_MAX - 1; i >= 0; i--)
      if (v[i]) r = 5'(i + 1);
    return r;
  endfunction

endpackage

// File: rtl/rpsc_dly_timer.sv
// Saturating run-length timer: done asserts on the TARGET-th consecutive run cycle.
module rpsc_dly_timer #(
  parameter int WIDTH  = 22,
  parameter int TARGET = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic done
);

  localparam logic [WIDTH-1:0] TGT  = WIDTH'(TARGET);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(TARGET - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run) cnt_d = (cnt_q == TGT) ? cnt_q : cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  // cnt_q counts completed run cycles, so the current cycle is number cnt_q+1.
  assign done = run && (cnt_q >= LAST);

endmodule

// File: rtl/rpsc_permit_seq.sv
// Power-supply permit sequencer: interlock latching, ramp delay and undervoltage trip.
// Optional first-fault capture is built only when RPSC_FIRST_FAULT_EN is defined.
module rpsc_permit_seq
  import rpsc_pkg::*;
#(
  parameter int N_ILK   = 7,
  parameter int TMR_W   = 22,
  parameter int OK_DLY  = 3125000,
  parameter int LOW_DLY = 3125000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_ILK-1:0] ilk,
  input  logic [N_ILK-1:0] ilk_mask,
  input  logic             ps_act,
  input  logic             u_low,
  input  logic             ack,
  output logic             on_perm,
  output logic             not_alarm,
  output logic             supply_ok,
  output logic             not_u_low,
  output logic [N_ILK-1:0] fault_lat,
  output logic             uv_lat,
  output logic [4:0]       first_fault,
  output logic [2:0]       state
);

  rpsc_state_e      state_q, state_d;
  logic [N_ILK-1:0] active, fault_lat_q, fault_lat_d;
  logic             uv_lat_q, uv_lat_d, not_u_low_q;
  logic             ok_done, low_done, lat_clr, uv_trip;

  assign active = ilk & ~ilk_mask;

  rpsc_dly_timer #(.WIDTH(TMR_W), .TARGET(OK_DLY)) u_ok_tmr (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == S_RAMP),
    .done  (ok_done)
  );

  rpsc_dly_timer #(.WIDTH(TMR_W), .TARGET(LOW_DLY)) u_low_tmr (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == S_RUN && u_low),
    .done  (low_done)
  );

  always_comb begin
    state_d = state_q;
    lat_clr = 1'b0;
    uv_trip = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ack && active == '0) lat_clr = 1'b1;
        if (active == '0 && fault_lat_q == '0 && !uv_lat_q) state_d = S_READY;
      end
      S_READY: begin
        if (active != '0) state_d = S_FAULT;
        else if (ps_act)  state_d = S_RAMP;
      end
      S_RAMP: begin
        if (active != '0)  state_d = S_FAULT;
        else if (!ps_act)  state_d = S_READY;
        else if (ok_done)  state_d = S_RUN;
      end
      S_RUN: begin
        if (active != '0) state_d = S_FAULT;
        else if (low_done) begin
          state_d = S_FAULT;
          uv_trip = 1'b1;
        end
        else if (!ps_act) state_d = S_READY;
      end
      S_FAULT: begin
        // A fault present alongside ack wins: stay here, latches untouched.
        if (ack && active == '0) begin
          state_d = S_IDLE;
          lat_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    fault_lat_d = lat_clr ? '0 : (fault_lat_q | active);
    uv_lat_d    = lat_clr ? 1'b0 : (uv_lat_q | uv_trip);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= S_IDLE;
      fault_lat_q <= '0;
      uv_lat_q    <= 1'b0;
      not_u_low_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      fault_lat_q <= fault_lat_d;
      uv_lat_q    <= uv_lat_d;
      not_u_low_q <= !(state_q == S_RUN && u_low);
    end

`ifdef RPSC_FIRST_FAULT_EN
  logic [4:0]           ff_q;
  logic [N_ILK_MAX-1:0] act_ext;

  assign act_ext = N_ILK_MAX'(active);

  always_ff @(posedge clk or posedge reset)
    if (reset)        ff_q <= '0;
    else if (lat_clr) ff_q <= '0;
    else if (state_d == S_FAULT && state_q != S_FAULT)
      ff_q <= (active != '0) ? ff_code(act_ext) : FF_UV;

  assign first_fault = ff_q;
`else
  assign first_fault = 5'd0;
`endif

  assign state     = state_q;
  assign on_perm   = (state_q == S_READY) || (state_q == S_RAMP) || (state_q == S_RUN);
  assign supply_ok = (state_q == S_RUN);
  assign not_alarm = (state_q != S_FAULT) && (fault_lat_q == '0);
  assign not_u_low = not_u_low_q;
  assign fault_lat = fault_lat_q;
  assign uv_lat    = uv_lat_q;

endmodule
